// File: rtl/mandelbrot_iterator_param.sv
// Handshaked Mandelbrot escape-time iterator: one z <= z^2 + c step per clock in signed fixed point.
// Optional build macro MANDEL_PERIOD_CHECK_EN adds periodicity detection so in-set points finish early.
module mandelbrot_iterator_param #(
  parameter int WIDTH  = 27,
  parameter int FRAC   = 23,
  parameter int ITER_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic signed [WIDTH-1:0]  cr,
  input  logic signed [WIDTH-1:0]  ci,
  input  logic        [ITER_W-1:0] max_iter,
  output logic                     ready,
  output logic                     done,
  input  logic                     ack,
  output logic        [ITER_W-1:0] num_iter,
  output logic                     escaped
);
  localparam int EW = WIDTH + 3;
  localparam int PW = 2 * WIDTH;
  localparam int SW = 2 * EW + 1;

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t                  state, state_n;
  logic signed [WIDTH-1:0] zr, zi, c_re, c_im;
  logic signed [WIDTH-1:0] zr_n, zi_n, c_re_n, c_im_n;
  logic        [ITER_W-1:0] count, count_n, limit, limit_n, num_iter_n;
  logic                    ready_n, done_n, escaped_n;

  logic signed [EW-1:0]    zr_nx, zi_nx;
  logic        [ITER_W-1:0] count_nx;
  logic                    esc_nx, period_hit;

  // Full-width product, arithmetic shift (floor), kept at the widened datapath width.
  function automatic logic signed [EW-1:0] fx_mul(input logic signed [WIDTH-1:0] a,
                                                  input logic signed [WIDTH-1:0] b);
    logic signed [PW-1:0] ax, bx, p;
    ax = {{(PW-WIDTH){a[WIDTH-1]}}, a};
    bx = {{(PW-WIDTH){b[WIDTH-1]}}, b};
    p  = (ax * bx) >>> FRAC;
    return p[EW-1:0];
  endfunction

  function automatic logic signed [EW-1:0] sext(input logic signed [WIDTH-1:0] a);
    return {{3{a[WIDTH-1]}}, a};
  endfunction

  // |z|>2 on either axis, or the untruncated squared magnitude exceeds 4.
  function automatic logic escape_test(input logic signed [EW-1:0] xr,
                                       input logic signed [EW-1:0] xi);
    logic signed [EW-1:0] two;
    logic signed [SW-1:0] xr_w, xi_w, four, mag;
    two  = '0;
    two[FRAC+1] = 1'b1;
    four = '0;
    four[2*FRAC+2] = 1'b1;
    xr_w = {{(SW-EW){xr[EW-1]}}, xr};
    xi_w = {{(SW-EW){xi[EW-1]}}, xi};
    mag  = xr_w * xr_w + xi_w * xi_w;
    return (xr > two) || (xr < -two) || (xi > two) || (xi < -two) || (mag > four);
  endfunction

  assign zr_nx    = fx_mul(zr, zr) - fx_mul(zi, zi) + sext(c_re);
  assign zi_nx    = (fx_mul(zr, zi) <<< 1) + sext(c_im);
  assign count_nx = count + ITER_W'(1);
  assign esc_nx   = escape_test(zr_nx, zi_nx);

`ifdef MANDEL_PERIOD_CHECK_EN
  logic signed [WIDTH-1:0] snap_r, snap_i, snap_r_n, snap_i_n;
  logic                    pow2;

  assign pow2       = (count_nx & (count_nx - ITER_W'(1))) == '0;
  assign period_hit = (zr_nx == sext(snap_r)) && (zi_nx == sext(snap_i));

  // The snapshot is compared before it is refreshed, so a new capture never matches itself.
  always_comb begin
    snap_r_n = snap_r;
    snap_i_n = snap_i;
    if (state == IDLE && start) begin
      snap_r_n = '0;
      snap_i_n = '0;
    end else if (state == ITER && !esc_nx && pow2) begin
      snap_r_n = zr_nx[WIDTH-1:0];
      snap_i_n = zi_nx[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      snap_r <= '0;
      snap_i <= '0;
    end else begin
      snap_r <= snap_r_n;
      snap_i <= snap_i_n;
    end
  end
`else
  assign period_hit = 1'b0;
`endif

  always_comb begin
    state_n    = state;
    zr_n       = zr;
    zi_n       = zi;
    c_re_n     = c_re;
    c_im_n     = c_im;
    count_n    = count;
    limit_n    = limit;
    num_iter_n = num_iter;
    escaped_n  = escaped;
    done_n     = done;
    ready_n    = ready;
    case (state)
      IDLE: begin
        ready_n = 1'b1;
        if (start) begin
          c_re_n  = cr;
          c_im_n  = ci;
          limit_n = max_iter;
          zr_n    = '0;
          zi_n    = '0;
          count_n = '0;
          ready_n = 1'b0;
          if (max_iter == '0) begin
            // done is raised from DONE itself, one edge after accept
            state_n    = DONE;
            num_iter_n = '0;
            escaped_n  = 1'b0;
          end else begin
            state_n = ITER;
          end
        end
      end
      ITER: begin
        if (esc_nx) begin
          state_n    = DONE;
          num_iter_n = count_nx;
          escaped_n  = 1'b1;
          done_n     = 1'b1;
        end else if (count_nx == limit || period_hit) begin
          state_n    = DONE;
          num_iter_n = limit;
          escaped_n  = 1'b0;
          done_n     = 1'b1;
        end else begin
          zr_n    = zr_nx[WIDTH-1:0];
          zi_n    = zi_nx[WIDTH-1:0];
          count_n = count_nx;
        end
      end
      DONE: begin
        done_n = 1'b1;
        if (ack && done) begin
          state_n = IDLE;
          done_n  = 1'b0;
          ready_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      zr       <= '0;
      zi       <= '0;
      c_re     <= '0;
      c_im     <= '0;
      count    <= '0;
      limit    <= '0;
      num_iter <= '0;
      escaped  <= 1'b0;
      done     <= 1'b0;
      ready    <= 1'b1;
    end else begin
      state    <= state_n;
      zr       <= zr_n;
      zi       <= zi_n;
      c_re     <= c_re_n;
      c_im     <= c_im_n;
      count    <= count_n;
      limit    <= limit_n;
      num_iter <= num_iter_n;
      escaped  <= escaped_n;
      done     <= done_n;
      ready    <= ready_n;
    end
  end

endmodule

// File: tb/tb_mandelbrot_iterator_param.sv
// Self-checking bench for mandelbrot_iterator_param: directed points, handshake corners, and
// randomized points scored against a plain-arithmetic escape-time model.
module tb_mandelbrot_iterator_param;
  localparam int W  = 27;
  localparam int F  = 23;
  localparam int IW = 32;
`ifdef MANDEL_PERIOD_CHECK_EN
  localparam bit PERIOD_EN = 1'b1;
`else
  localparam bit PERIOD_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset, start, ack;
  logic signed [W-1:0]  cr, ci;
  logic        [IW-1:0] max_iter;
  logic                 ready, done, escaped;
  logic        [IW-1:0] num_iter;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mandelbrot_iterator_param #(.WIDTH(W), .FRAC(F), .ITER_W(IW)) dut (
    .clk(clk), .reset(reset), .start(start), .cr(cr), .ci(ci), .max_iter(max_iter),
    .ready(ready), .done(done), .ack(ack), .num_iter(num_iter), .escaped(escaped)
  );

  // Escape-time reference: iterate real-valued-style fixed point with 64-bit integers.
  function automatic void ref_model(input longint a, input longint b, input longint lim,
                                    output int n, output bit e);
    longint zr, zi, nr, ni, two, four;
    zr = 0; zi = 0;
    two  = longint'(2) << F;
    four = longint'(4) << (2 * F);
    n = int'(lim);
    e = 1'b0;
    for (longint k = 1; k <= lim; k++) begin
      nr = ((zr * zr) >>> F) - ((zi * zi) >>> F) + a;
      ni = 2 * ((zr * zi) >>> F) + b;
      if (nr > two || nr < -two || ni > two || ni < -two || (nr * nr + ni * ni) > four) begin
        n = int'(k);
        e = 1'b1;
        return;
      end
      zr = nr;
      zi = ni;
    end
  endfunction

  // Accept one point, scramble the inputs afterwards, and count edges until done.
  task automatic run_point(input int a, input int b, input int m, input int pulse_at,
                           output int edges, output bit to);
    cr = a[W-1:0];
    ci = b[W-1:0];
    max_iter = IW'(m);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cr = ~cr;
    ci = -ci;
    max_iter = IW'(3);
    edges = 0;
    to = 1'b0;
    while (done !== 1'b1 && !to) begin
      @(posedge clk); #1;
      edges++;
      start = (edges == pulse_at);
      if (edges > m + 10) to = 1'b1;
    end
    start = 1'b0;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; ack = 1'b0; cr = '0; ci = '0; max_iter = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    n_checks++;
    if (ready !== 1'b1 || done !== 1'b0 || num_iter !== '0 || escaped !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b done=%b num_iter=%0d escaped=%b, want 1 0 0 0",
               ready, done, num_iter, escaped);
    end
  endtask

  task automatic test_directed();
    int tr[4] = '{32'h400000, 32'h800000, 32'h1000000, -32'h200000};
    int ti[4] = '{32'h400000, 32'h800000, 32'h1000000, -32'h600000};
    int tn[4] = '{5, 2, 1, 22};
    int edges;
    bit to;
    for (int i = 0; i < 4; i++) begin
      run_point(tr[i], ti[i], 1000, -1, edges, to);
      n_checks++;
      if (to || num_iter !== IW'(tn[i]) || escaped !== 1'b1) begin
        n_fail++;
        $display("FAIL directed_%0d: num_iter=%0d escaped=%b timeout=%b, want %0d 1 0",
                 i, num_iter, escaped, to, tn[i]);
      end
      n_checks++;
      if (edges != tn[i]) begin
        n_fail++;
        $display("FAIL directed_latency_%0d: done after %0d edges, want %0d", i, edges, tn[i]);
      end
      do_ack();
      n_checks++;
      if (done !== 1'b0 || ready !== 1'b1) begin
        n_fail++;
        $display("FAIL directed_ack_%0d: done=%b ready=%b, want 0 1", i, done, ready);
      end
    end
  endtask

  task automatic test_in_set();
    int edges;
    bit to;
    run_point(0, 0, 1000, -1, edges, to);
    n_checks++;
    if (to || num_iter !== IW'(1000) || escaped !== 1'b0) begin
      n_fail++;
      $display("FAIL in_set: num_iter=%0d escaped=%b timeout=%b, want 1000 0 0", num_iter, escaped, to);
    end
    n_checks++;
`ifdef MANDEL_PERIOD_CHECK_EN
    if (edges > 3) begin
      n_fail++;
      $display("FAIL in_set_latency: done after %0d edges, want at most 3", edges);
    end
`else
    if (edges != 1000) begin
      n_fail++;
      $display("FAIL in_set_latency: done after %0d edges, want 1000", edges);
    end
`endif
    do_ack();
  endtask

  task automatic test_hold_ack();
    int edges;
    bit to;
    run_point(32'h400000, 32'h400000, 1000, -1, edges, to);
    for (int k = 0; k < 10; k++) begin
      start = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (done !== 1'b1 || num_iter !== IW'(5) || escaped !== 1'b1 || ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_ack_%0d: done=%b num_iter=%0d escaped=%b ready=%b, want 1 5 1 0",
                 k, done, num_iter, escaped, ready);
      end
    end
    start = 1'b0;
    do_ack();
    n_checks++;
    if (done !== 1'b0 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_ack_release: done=%b ready=%b, want 0 1", done, ready);
    end
  endtask

  task automatic test_start_during_iter();
    int edges;
    bit to;
    run_point(32'h400000, 32'h400000, 1000, 2, edges, to);
    n_checks++;
    if (to || num_iter !== IW'(5) || escaped !== 1'b1 || edges != 5) begin
      n_fail++;
      $display("FAIL start_during_iter: num_iter=%0d escaped=%b edges=%0d timeout=%b, want 5 1 5 0",
               num_iter, escaped, edges, to);
    end
    do_ack();
  endtask

  task automatic test_zero_iter();
    int edges;
    bit to;
    run_point(32'h400000, 32'h400000, 0, -1, edges, to);
    n_checks++;
    if (to || num_iter !== '0 || escaped !== 1'b0 || edges != 1) begin
      n_fail++;
      $display("FAIL zero_iter: num_iter=%0d escaped=%b edges=%0d timeout=%b, want 0 0 1 0",
               num_iter, escaped, edges, to);
    end
    do_ack();
  endtask

  task automatic test_start_ack_together();
    int edges;
    bit to;
    run_point(32'h1000000, 32'h1000000, 1000, -1, edges, to);
    n_checks++;
    if (to || num_iter !== IW'(1) || escaped !== 1'b1) begin
      n_fail++;
      $display("FAIL start_ack_setup: num_iter=%0d escaped=%b, want 1 1", num_iter, escaped);
    end
    start = 1'b1; ack = 1'b1; cr = 27'h400000; ci = 27'h400000; max_iter = IW'(1000);
    @(posedge clk); #1;
    start = 1'b0; ack = 1'b0;
    n_checks++;
    if (done !== 1'b0 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL start_ack_together: done=%b ready=%b, want 0 1", done, ready);
    end
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL start_ack_no_accept: done=%b ready=%b, want 0 1", done, ready);
    end
  endtask

  task automatic test_reset_mid_iter();
    int edges;
    bit to;
    cr = '0; ci = '0; max_iter = IW'(1000);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_checks++;
    if (ready !== 1'b1 || done !== 1'b0 || num_iter !== '0 || escaped !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_iter: ready=%b done=%b num_iter=%0d escaped=%b, want 1 0 0 0",
               ready, done, num_iter, escaped);
    end
    run_point(32'h400000, 32'h400000, 1000, -1, edges, to);
    n_checks++;
    if (to || num_iter !== IW'(5) || escaped !== 1'b1 || edges != 5) begin
      n_fail++;
      $display("FAIL reset_fresh_run: num_iter=%0d escaped=%b edges=%0d, want 5 1 5", num_iter, escaped, edges);
    end
    do_ack();
  endtask

  task automatic test_random();
    int range;
    int a, b, m, en, edges;
    bit ee, to;
    range = 18454937;
    for (int i = 0; i < 24; i++) begin
      a = int'($urandom_range(0, 2 * range)) - range;
      b = int'($urandom_range(0, 2 * range)) - range;
      m = int'($urandom_range(1, 150));
      ref_model(longint'(a), longint'(b), longint'(m), en, ee);
      run_point(a, b, m, -1, edges, to);
      n_checks++;
      if (to || num_iter !== IW'(en) || escaped !== ee) begin
        n_fail++;
        $display("FAIL random_%0d c=(%0d,%0d) max=%0d: num_iter=%0d escaped=%b timeout=%b, want %0d %b",
                 i, a, b, m, num_iter, escaped, to, en, ee);
      end
      if (ee || !PERIOD_EN) begin
        n_checks++;
        if (edges != en) begin
          n_fail++;
          $display("FAIL random_latency_%0d: done after %0d edges, want %0d", i, edges, en);
        end
      end
      do_ack();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_in_set();
    test_hold_ack();
    test_start_during_iter();
    test_zero_iter();
    test_start_ack_together();
    test_reset_mid_iter();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
